// File: rtl/mem_word_ctrl.sv
// ============================================================================
// Module      : mem_word_ctrl
// Description : Request-driven single-word access sequencer over a
//               DEPTH x WIDTH register array with one-hot select/rw
//               outputs, read-data valid pulse and out-of-range error.
//               Optional macro: MEM_CLEAR_ON_RESET_EN (reset clears storage).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_word_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic              ready,
    output logic              busy,
    output logic              rw,
    output logic [DEPTH-1:0]  sel,
    output logic [WIDTH-1:0]  rdata,
    output logic              valid,
    output logic              err
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_write = 2'd1;
    localparam logic [1:0] c_read  = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [1:0]        r_state;
    logic              r_ready;
    logic              r_rw;
    logic [DEPTH-1:0]  r_sel;
    logic [WIDTH-1:0]  r_rdata;
    logic              r_valid;
    logic              r_err;
    logic              r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_wdata;

    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic [DEPTH-1:0]  w_sel_next;
    logic              w_in_range;
    logic              w_write;

    // Decoded from the request address at capture so sel is registered;
    // an out-of-range address matches no word and yields all-zero.
    for (genvar g = 0; g < DEPTH; g++) begin : g_sel
        localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(g);
        assign w_sel_next[g] = (addr == c_idx);
    end

    assign w_in_range = ({1'b0, r_addr} < c_depth);
    assign w_write    = (r_state == c_write) && w_in_range && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
            r_ready <= 1'b1;
            r_rw    <= 1'b0;
            r_sel   <= '0;
            r_rdata <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_op    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (req) begin
                        r_op    <= op;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_state <= op ? c_write : c_read;
                        r_ready <= 1'b0;
                        r_rw    <= op;
                        r_sel   <= w_sel_next;
                    end
                end
                c_write: begin
                    r_state <= c_done;
                    r_rw    <= 1'b0;
                    r_sel   <= '0;
                    r_valid <= 1'b1;
                    r_err   <= !w_in_range;
                end
                c_read: begin
                    r_state <= c_done;
                    r_sel   <= '0;
                    r_rdata <= w_in_range ? r_mem[r_addr] : '0;
                    r_valid <= 1'b1;
                    r_err   <= !w_in_range;
                end
                c_done: begin
                    r_state <= c_idle;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= c_idle;
                    r_ready <= 1'b1;
                    r_rw    <= 1'b0;
                    r_sel   <= '0;
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end
`else
    // Storage deliberately has no reset; w_write already blocks reset cycles.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end
`endif

    assign ready = r_ready;
    assign busy  = !r_ready;
    assign rw    = r_rw;
    assign sel   = r_sel;
    assign rdata = r_rdata;
    assign valid = r_valid;
    assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_word_ctrl.sv
// ============================================================================
// Module      : tb_mem_word_ctrl
// Description : Directed self-checking bench for mem_word_ctrl; a DEPTH=4
//               and a DEPTH=3 instance share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_word_ctrl;

    logic       clk;
    logic       reset;
    logic       req;
    logic       op;
    logic [1:0] addr;
    logic [7:0] wdata;

    logic       ready_a, busy_a, rw_a, valid_a, err_a;
    logic [3:0] sel_a;
    logic [7:0] rdata_a;
    logic       ready_b, busy_b, rw_b, valid_b, err_b;
    logic [2:0] sel_b;
    logic [7:0] rdata_b;

    int vectors;
    int miscompares;
    int valid_count;

    mem_word_ctrl #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) u_dut_a (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .ready(ready_a), .busy(busy_a), .rw(rw_a), .sel(sel_a),
        .rdata(rdata_a), .valid(valid_a), .err(err_a)
    );

    mem_word_ctrl #(.WIDTH(8), .DEPTH(3), .ADDR_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .ready(ready_b), .busy(busy_b), .rw(rw_b), .sel(sel_b),
        .rdata(rdata_b), .valid(valid_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full access on instance a (b=0) or instance b (b=1), starting in IDLE.
    task automatic access(input int b, input logic o, input logic [1:0] a, input logic [7:0] d,
                          input logic [3:0] exp_sel, input logic exp_err,
                          input logic chk_rd, input logic [7:0] exp_rd);
        chk("ready_idle", b ? ready_b : ready_a, 1'b1);
        req = 1'b1; op = o; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        chk("ready_access", b ? ready_b : ready_a, 1'b0);
        chk("busy_access",  b ? busy_b  : busy_a,  1'b1);
        chk("rw_access",    b ? rw_b    : rw_a,    o);
        chk("sel_access",   b ? {1'b0, sel_b} : sel_a, exp_sel);
        chk("valid_access", b ? valid_b : valid_a, 1'b0);
        @(negedge clk);
        chk("ready_done", b ? ready_b : ready_a, 1'b0);
        chk("valid_done", b ? valid_b : valid_a, 1'b1);
        chk("err_done",   b ? err_b   : err_a,   exp_err);
        chk("sel_done",   b ? {1'b0, sel_b} : sel_a, 4'b0000);
        chk("rw_done",    b ? rw_b    : rw_a,    1'b0);
        if (chk_rd) chk("rdata_done", b ? rdata_b : rdata_a, exp_rd);
        @(negedge clk);
        chk("valid_after", b ? valid_b : valid_a, 1'b0);
        chk("err_after",   b ? err_b   : err_a,   1'b0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; valid_count = 0;
        reset = 1'b1; req = 1'b0; op = 1'b0; addr = 2'd0; wdata = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_ready", ready_a, 1'b1);
        chk("rst_busy",  busy_a,  1'b0);
        chk("rst_rw",    rw_a,    1'b0);
        chk("rst_sel",   sel_a,   4'b0000);
        chk("rst_rdata", rdata_a, 8'h00);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_err",   err_a,   1'b0);
        chk("rst_ready_b", ready_b, 1'b1);

        // Write then read-back of a single word
        access(0, 1'b1, 2'd2, 8'hA5, 4'b0100, 1'b0, 1'b0, 8'h00);
        access(0, 1'b0, 2'd2, 8'h00, 4'b0100, 1'b0, 1'b1, 8'hA5);

        // Fill all words, then read back out of order
        access(0, 1'b1, 2'd0, 8'h11, 4'b0001, 1'b0, 1'b0, 8'h00);
        access(0, 1'b1, 2'd1, 8'h22, 4'b0010, 1'b0, 1'b0, 8'h00);
        access(0, 1'b1, 2'd2, 8'h33, 4'b0100, 1'b0, 1'b0, 8'h00);
        access(0, 1'b1, 2'd3, 8'h44, 4'b1000, 1'b0, 1'b0, 8'h00);
        access(0, 1'b0, 2'd3, 8'h00, 4'b1000, 1'b0, 1'b1, 8'h44);
        access(0, 1'b0, 2'd0, 8'h00, 4'b0001, 1'b0, 1'b1, 8'h11);
        access(0, 1'b0, 2'd1, 8'h00, 4'b0010, 1'b0, 1'b1, 8'h22);
        access(0, 1'b0, 2'd2, 8'h00, 4'b0100, 1'b0, 1'b1, 8'h33);

        // Out-of-range address on the DEPTH=3 instance
        access(1, 1'b1, 2'd3, 8'hFF, 4'b0000, 1'b1, 1'b0, 8'h00);
        access(1, 1'b0, 2'd3, 8'h00, 4'b0000, 1'b1, 1'b1, 8'h00);
        access(1, 1'b0, 2'd2, 8'h00, 4'b0100, 1'b0, 1'b1, 8'h33);

        // req held high with op toggling every cycle: only IDLE cycles accept
        req = 1'b1; addr = 2'd0; wdata = 8'h66;
        for (int c = 0; c < 6; c++) begin
            op = (c % 2 == 0);
            if (c == 0 || c == 3) chk("held_ready_hi", ready_a, 1'b1);
            else                  chk("held_ready_lo", ready_a, 1'b0);
            @(negedge clk);
            if (valid_a) valid_count++;
            if (c == 0) chk("held_rw_write", rw_a, 1'b1);
            if (c == 3) chk("held_rw_read",  rw_a, 1'b0);
            if (c == 4) chk("held_rdata",    rdata_a, 8'h66);
        end
        req = 1'b0;
        chk("held_valid_count", valid_count, 2);
        @(negedge clk);

        // Reset during the WRITE cycle aborts the write
        access(0, 1'b1, 2'd1, 8'h5A, 4'b0010, 1'b0, 1'b0, 8'h00);
        req = 1'b1; op = 1'b1; addr = 2'd1; wdata = 8'hC3;
        @(negedge clk);
        req = 1'b0;
        chk("abort_rw", rw_a, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_valid", valid_a, 1'b0);
        chk("abort_ready", ready_a, 1'b1);
        chk("abort_sel",   sel_a,   4'b0000);
        @(negedge clk);
        chk("abort_valid2", valid_a, 1'b0);
`ifdef MEM_CLEAR_ON_RESET_EN
        access(0, 1'b0, 2'd1, 8'h00, 4'b0010, 1'b0, 1'b1, 8'h00);
`else
        access(0, 1'b0, 2'd1, 8'h00, 4'b0010, 1'b0, 1'b1, 8'h5A);
`endif

        // Reset during a READ cycle
        req = 1'b1; op = 1'b0; addr = 2'd2; wdata = 8'h00;
        @(negedge clk);
        req = 1'b0;
        chk("rdabort_ready_lo", ready_a, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rdabort_ready", ready_a, 1'b1);
        chk("rdabort_valid", valid_a, 1'b0);
        chk("rdabort_rdata", rdata_a, 8'h00);
        @(negedge clk);
        chk("rdabort_valid2", valid_a, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
